uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver that turns the asynchronous `rx` pin into byte-wide `data` plus a one-cycle `ready` strobe. It sits directly upstream of the LED indicator and any other byte consumers on the same bus. It oversamples by a fixed clock divider and validates the start bit at mid-bit. Each frame is sampled at bit centres. Frames with errors are flagged on `err` and never strobed on `ready`.

## Interface
- `CLK_DIV`, default 104: clocks per bit (12 MHz / 115200). Integer, ≥ 4. Counter width is `$clog2(CLK_DIV)`.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `rx` in 1: raw serial line, idle high, asynchronous to `clk`.
- `data` out 8: last good byte; holds until the next good frame.
- `ready` out 1: one-cycle pulse when `data` updates.
- `err` out 1: one-cycle pulse on a framing error (or parity error, see Configuration).
- `busy` out 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. `rxs` is the second flop's output.
- FSM states are IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE, `rxs`==0: go to START; `cnt`←CLK_DIV/2−1 (integer divide).
- All non-IDLE states: `cnt` decrements each cycle. A sample occurs on the edge where `cnt`==0, which also reloads `cnt`←CLK_DIV−1.
- START sample, `rxs`==0: go to DATA; `bitidx`←0.
- START sample, `rxs`==1: glitch; return to IDLE with no outputs.
- DATA sample: shift `rxs` into the shift register MSB and shift right (data is LSB first); `bitidx`++.
- After the 8th data sample: go to PARITY if enabled, else STOP.
- STOP sample, `rxs`==1: `data`←shift register, `ready`←1 for one cycle, go to IDLE.
- Returning to IDLE at mid-stop-bit lets the block catch a start bit that immediately follows the stop bit.
- STOP sample, `rxs`==0: `err`←1 for one cycle, `data` unchanged, go to BREAK.
- BREAK: wait until `rxs`==1, then go to IDLE. A held-low line therefore produces exactly one `err`.
- `ready` and `err` are never high in the same cycle.

## Timing
- Reset values: `data`=0x00, `ready`=0, `err`=0, `busy`=0, state IDLE, synchronizer=1.
- Edge 0 is the first posedge at which `rxs`==0 in IDLE. Raw `rx` reaches `rxs` 2 edges earlier.
- Start sample occurs at edge S=CLK_DIV/2.
- Data bit k (0..7) is sampled at S+(k+1)·CLK_DIV.
- Stop bit is sampled at S+9·CLK_DIV, or S+10·CLK_DIV with parity.
- `ready`/`err` are high in the cycle following the stop-sample edge.
- `busy` rises the cycle after edge 0 and falls with the stop-sample edge (the cycle `ready` is high).
- Reset mid-frame: abort immediately; no `ready` or `err`; the next frame after reset release is received normally.
- Tolerates about ±4% total baud mismatch, since the stop-bit sample must land inside the stop bit.

## Configuration
- `UART_RX_PARITY_EN` defined: an even-parity bit follows data bit 7.
  - PARITY state samples it. The stop bit then comes one bit later.
  - Parity mismatch with a good stop bit: `err` pulse, no `ready`, `data` unchanged, go to IDLE.
  - Parity mismatch with a bad stop bit: a single `err` pulse, then go to BREAK.
- `UART_RX_PARITY_EN` undefined: the frame is 8N1. The PARITY state and its logic are absent.

## Test plan
All cases use CLK_DIV=16 unless noted.
- 8N1 frame 0x31 ('1') → exactly one `ready` pulse at edge 8+9·16=152 after edge 0; `data`=0x31; `err`=0; `busy` 0 afterwards.
- Back-to-back 0x32 then 0x35, second start bit immediately after a 1-bit stop → two `ready` pulses 160 cycles apart; `data`=0x32 then 0x35.
- `rx` low for 4 cycles, then high → no `ready`/`err`; `busy` high briefly, then back to IDLE; a following 0x34 frame is received correctly.
- Frame 0x33 with stop=0, line held low for 20 bit times, then a valid 0x36 → one `err` pulse; `data` stays at its prior value until 0x36 gives `ready`.
- `reset` pulsed during data bit 4 of 0x37 → `busy`=0 and `ready`=0 immediately; a following 0x38 frame is received correctly.
- With `UART_RX_PARITY_EN`, 0x31 with parity 1 → `ready`, `data`=0x31. The same frame with parity 0 → `err` pulse, no `ready`.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input line and received-byte outputs of the UART receiver
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       ready;
    logic       err;
    logic       busy;
    modport master (output rx, input data, ready, err, busy);
    modport slave  (input rx, output data, ready, err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8-bit serial receiver sampled at bit centres; even parity when UART_RX_PARITY_EN is defined
module uart_rx #(
    parameter int CLK_DIV = 104
) (
    input logic      clk,
    input logic      reset,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitidx_q, bitidx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          rxs, tick;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d;
`endif
    assign rxs       = sync_q[1];
    assign tick      = cnt_q == '0;
    assign bus.data  = data_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = state_q != IDLE;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], bus.rx};
    end

    // FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitidx_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
`ifdef UART_RX_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    // Next state: bit-centre sampling whenever the bit counter expires
    always_comb begin
        state_d  = state_q;
        cnt_d    = state_q == IDLE ? cnt_q : (tick ? FULL : cnt_q - 1'b1);
        bitidx_d = bitidx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        ready_d  = 1'b0;
        err_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d   = perr_q;
`endif
        case (state_q)
            IDLE: if (!rxs) begin
                state_d = START;
                cnt_d   = HALF;
            end
            START: if (tick) begin
                state_d  = rxs ? IDLE : DATA;
                bitidx_d = '0;
            end
            DATA: if (tick) begin
                shift_d  = {rxs, shift_q[7:1]};
                bitidx_d = bitidx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                if (bitidx_q == 3'd7) state_d = PARITY;
`else
                if (bitidx_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                perr_d  = ^{shift_q, rxs};
                state_d = STOP;
            end
`endif
            STOP: if (tick) begin
`ifdef UART_RX_PARITY_EN
                err_d   = !rxs || perr_q;
`else
                err_d   = !rxs;
`endif
                ready_d = !err_d;
                data_d  = err_d ? data_q : shift_q;
                state_d = rxs ? IDLE : BREAK;
            end
            BREAK: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, directed and randomized frame checks of uart_rx against a frame-level model
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CLK_DIV = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // rx driven low at a falling edge -> 2 sync edges -> edge 0 -> stop sample -> strobe seen next falling edge
    localparam int LAT = 3 + CLK_DIV / 2 + (NBITS - 1) * CLK_DIV;

    typedef struct {
        int         cyc;
        logic       r;
        logic       e;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         gap;
        logic       exp_r;
        logic       exp_e;
        logic [7:0] exp_d;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  ev_q[$];

    uart_rx_if bus();
    uart_rx #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Record every strobe with its cycle; ready and err must never coincide
    always @(negedge clk) begin
        if (!reset && (bus.ready || bus.err)) begin
            check("ready_err_exclusive", int'(bus.ready && bus.err), 0);
            ev_q.push_back('{cyc, bus.ready, bus.err, bus.data});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(logic b);
        bus.rx = b;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_frame(logic [7:0] d, logic stop, logic flip, output int c0);
        c0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ flip);
`else
        if (flip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop);
    endtask

    task automatic expect_frame(string name, int c0, logic er, logic ee, logic [7:0] ed);
        check({name, " events"}, ev_q.size(), 1);
        if (ev_q.size() == 1) begin
            check({name, " cycle"}, ev_q[0].cyc, c0 + LAT);
            check({name, " ready"}, ev_q[0].r, er);
            check({name, " err"}, ev_q[0].e, ee);
            check({name, " data@strobe"}, ev_q[0].d, ed);
        end
        check({name, " data"}, bus.data, ed);
        ev_q.delete();
    endtask

    initial begin
        vec_t       tbl[9];
        int         rc[9];
        int         c0;
        logic [7:0] model_d;
        logic [7:0] d;
        logic       stop, flip, good;
        int         gap;
        tbl[0] = '{8'h31, 1'b1, 2, 1'b1, 1'b0, 8'h31};
        tbl[1] = '{8'h32, 1'b1, 0, 1'b1, 1'b0, 8'h32};
        tbl[2] = '{8'h35, 1'b1, 2, 1'b1, 1'b0, 8'h35};
        tbl[3] = '{8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        tbl[4] = '{8'hFF, 1'b1, 1, 1'b1, 1'b0, 8'hFF};
        tbl[5] = '{8'hA5, 1'b0, 2, 1'b0, 1'b1, 8'hFF};
        tbl[6] = '{8'h5A, 1'b1, 1, 1'b1, 1'b0, 8'h5A};
        tbl[7] = '{8'h80, 1'b0, 1, 1'b0, 1'b1, 8'h5A};
        tbl[8] = '{8'h01, 1'b1, 2, 1'b1, 1'b0, 8'h01};
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset data", bus.data, 0);
        check("reset ready", bus.ready, 0);
        check("reset err", bus.err, 0);
        check("reset busy", bus.busy, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle busy", bus.busy, 0);

        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].d, tbl[i].stop, 1'b0, c0);
            rc[i] = ev_q.size() > 0 ? ev_q[0].cyc : 0;
            expect_frame($sformatf("vec%0d", i), c0, tbl[i].exp_r, tbl[i].exp_e, tbl[i].exp_d);
            check($sformatf("vec%0d busy", i), bus.busy, int'(!tbl[i].stop));
            repeat (tbl[i].gap) send_bit(1'b1);
        end
        check("back_to_back spacing", rc[2] - rc[1], NBITS * CLK_DIV);
        model_d = 8'h01;

        // Start-bit glitch: 4 cycles low
        c0 = cyc;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        check("glitch busy high", bus.busy, 1);
        repeat (16) @(negedge clk);
        check("glitch busy low", bus.busy, 0);
        check("glitch no strobe", ev_q.size(), 0);
        send_frame(8'h34, 1'b1, 1'b0, c0);
        model_d = 8'h34;
        expect_frame("after_glitch", c0, 1'b1, 1'b0, model_d);
        send_bit(1'b1);

        // Bad stop bit then line held low for 20 bit times
        send_frame(8'h33, 1'b0, 1'b0, c0);
        repeat (20 * CLK_DIV) @(negedge clk);
        expect_frame("break", c0, 1'b0, 1'b1, model_d);
        check("break busy", bus.busy, 1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("break released", bus.busy, 0);
        send_frame(8'h36, 1'b1, 1'b0, c0);
        model_d = 8'h36;
        expect_frame("after_break", c0, 1'b1, 1'b0, model_d);
        send_bit(1'b1);

        // Reset in the middle of data bit 4 of 0x37
        d = 8'h37;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        bus.rx = d[4];
        repeat (CLK_DIV / 2) @(negedge clk);
        check("pre_reset busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("mid_reset busy", bus.busy, 0);
        check("mid_reset ready", bus.ready, 0);
        check("mid_reset data", bus.data, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.rx = 1'b1;
        model_d = 8'h00;
        repeat (2 * CLK_DIV) @(negedge clk);
        check("post_reset no strobe", ev_q.size(), 0);
        check("post_reset busy", bus.busy, 0);
        send_frame(8'h38, 1'b1, 1'b0, c0);
        model_d = 8'h38;
        expect_frame("after_reset", c0, 1'b1, 1'b0, model_d);
        send_bit(1'b1);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h31, 1'b1, 1'b0, c0);
        model_d = 8'h31;
        expect_frame("parity_ok", c0, 1'b1, 1'b0, model_d);
        send_bit(1'b1);
        send_frame(8'h31, 1'b1, 1'b1, c0);
        expect_frame("parity_bad", c0, 1'b0, 1'b1, model_d);
        send_bit(1'b1);
`endif

        // Random frames against the frame-level model
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            stop = $urandom_range(0, 5) != 0;
`ifdef UART_RX_PARITY_EN
            flip = $urandom_range(0, 3) == 0;
`else
            flip = 1'b0;
`endif
            gap = $urandom_range(0, 2);
            if (!stop && gap == 0) gap = 1;
            good = stop && !flip;
            send_frame(d, stop, flip, c0);
            if (good) model_d = d;
            expect_frame($sformatf("rand%0d", i), c0, good, !good, model_d);
            repeat (gap) send_bit(1'b1);
        end

        bus.rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        check("final no stray strobe", ev_q.size(), 0);
        check("final busy", bus.busy, 0);
        check("final data", bus.data, model_d);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
